vectored_irq_unit: RTL and testbench

- Parametrised successor to the CPU's single-purpose ecall/halt interrupt logic.
- Adds N external interrupt channels with fixed priority and nested preemption, plus an EPC stack.
- Keeps the ecall services: LED print and halt.
- Sits beside the PC register. Drives a PC redirect that overrides PCNext and consumes the decoded ecall/uret strobes.

---
 rtl/vectored_irq_unit.sv | 148 ++++++++++++++
 tb/tb_vectored_irq_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vectored_irq_unit.sv
// vectored_irq_unit: fixed-priority, nesting interrupt controller that sits
// beside the PC register. It redirects the PC to a per-channel handler vector
// or back to a saved EPC, and it services the ecall LED-print and halt calls.
// Optional build macro IRQ_MASK_EN adds a per-channel mask that is loaded by
// ecall service 50.
module vectored_irq_unit #(
    parameter int          WIDTH       = 32,
    parameter int          NUM_IRQ     = 3,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
    parameter int          VEC_SHIFT   = 4,
    parameter int          ECALL_PRINT = 34,
    parameter int          ECALL_HALT  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ecall,
    input  logic               uret,
    input  logic [WIDTH-1:0]   R1,
    input  logic [WIDTH-1:0]   R2,
    input  logic [WIDTH-1:0]   pc_next,
    output logic               redirect,
    output logic [WIDTH-1:0]   redirect_pc,
    output logic [WIDTH-1:0]   ledData,
    output logic               halt,
    output logic [NUM_IRQ-1:0] in_service
);

    // Level numbers run 0..NUM_IRQ (0 = not in any handler). The stack pointer
    // uses the same width. The stack is sized to the full index range so that
    // sp indexes it directly; entries beyond NUM_IRQ-1 are never written.
    localparam int LVL_W = $clog2(NUM_IRQ + 1);
    localparam int STK_D = 1 << LVL_W;

    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] cand_oh;
    logic [NUM_IRQ-1:0] top_oh;
    logic [LVL_W-1:0]   cand_id;
    logic [LVL_W-1:0]   cur_lvl;
    logic [LVL_W-1:0]   sp;
    logic [LVL_W-1:0]   sp_dec;
    logic               cand_vld;
    logic               take;
    logic               uret_ok;
    logic               ecall_ok;
    logic [WIDTH-1:0]   vector;
    logic [WIDTH-1:0]   stack [STK_D];

    assign rise   = irq & ~irq_prev;
    assign sp_dec = sp - LVL_W'(1);

    // Priority scan: find the highest pending+unmasked channel and the
    // highest channel currently in service (that one sets the current level).
    always_comb begin
        cand_vld = 1'b0;
        cand_id  = '0;
        cand_oh  = '0;
        cur_lvl  = '0;
        top_oh   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending[i] && mask[i]) begin
                cand_vld   = 1'b1;
                cand_id    = LVL_W'(i);
                cand_oh    = '0;
                cand_oh[i] = 1'b1;
            end
            if (in_service[i]) begin
                cur_lvl   = LVL_W'(i + 1);
                top_oh    = '0;
                top_oh[i] = 1'b1;
            end
        end
    end

    // Take/return decision and the combinational PC redirect. A handler
    // return has priority over a new take; an ecall defers a take by a cycle.
    always_comb begin
        ecall_ok    = ecall && !halt;
        uret_ok     = uret && !halt && (sp != '0);
        take        = cand_vld && ((cand_id + LVL_W'(1)) > cur_lvl) &&
                      !halt && !uret && !ecall;
        vector      = WIDTH'(VEC_BASE) + (WIDTH'(cand_id) << VEC_SHIFT);
        redirect    = uret_ok || take;
        redirect_pc = '0;
        if (uret_ok) begin
            redirect_pc = stack[sp_dec];
        end else if (take) begin
            redirect_pc = vector;
        end
    end

    // Control state: edge detect, pending, nesting level, ecall services.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev   <= '0;
            pending    <= '0;
            in_service <= '0;
            sp         <= '0;
            halt       <= 1'b0;
            ledData    <= '0;
        end else begin
            irq_prev <= irq;
            // A new edge on the channel being taken re-pends it (set wins).
            pending  <= (pending & ~(take ? cand_oh : '0)) | rise;
            if (take) begin
                in_service <= in_service | cand_oh;
                sp         <= sp + LVL_W'(1);
            end else if (uret_ok) begin
                in_service <= in_service & ~top_oh;
                sp         <= sp_dec;
            end
            if (ecall_ok) begin
                if (R1 == WIDTH'(ECALL_PRINT)) begin
                    ledData <= R2;
                end
                if (R1 == WIDTH'(ECALL_HALT)) begin
                    halt <= 1'b1;
                end
            end
        end
    end

    // EPC stack storage; contents are meaningless until pushed.
    always_ff @(posedge clk) begin
        if (take) begin
            stack[sp] <= pc_next;
        end
    end

`ifdef IRQ_MASK_EN
    localparam int ECALL_MASK = 50;

    // Channel mask, loaded by ecall service 50; masked channels stay pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '1;
        end else if (ecall && !halt && (R1 == WIDTH'(ECALL_MASK))) begin
            mask <= R2[NUM_IRQ-1:0];
        end
    end
`else
    assign mask = '1;
`endif

endmodule

// File: tb/tb_vectored_irq_unit.sv
// Testbench for vectored_irq_unit: directed scenarios followed by a random
// phase, all checked against a queue-based reference model.
module tb_vectored_irq_unit;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] irq;
    logic        ecall;
    logic        uret;
    logic [31:0] R1;
    logic [31:0] R2;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ledData;
    logic        halt;
    logic [N-1:0] in_service;

    int n_tests = 0;
    int n_fail  = 0;

    vectored_irq_unit dut (
        .clk(clk), .rst(rst), .irq(irq), .ecall(ecall), .uret(uret),
        .R1(R1), .R2(R2), .pc_next(pc_next), .redirect(redirect),
        .redirect_pc(redirect_pc), .ledData(ledData), .halt(halt),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    // Reference model: handler nesting kept as a stack of (channel, EPC).
    bit          m_pend [N];
    bit          m_prev [N];
    bit          m_mask [N];
    int          m_ids [$];
    logic [31:0] m_pcs [$];
    bit          m_halt;
    logic [31:0] m_led;
    bit          e_red;
    logic [31:0] e_pc;
    bit          m_take;
    bit          m_uret;
    int          m_cand;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
            m_mask[i] = 1;
        end
        m_ids.delete();
        m_pcs.delete();
        m_halt = 0;
        m_led  = 0;
    endfunction

    function automatic logic [31:0] exp_isvc();
        logic [31:0] v = 0;
        foreach (m_ids[k]) v = v | (32'd1 << m_ids[k]);
        return v;
    endfunction

    function automatic void model_comb();
        int cur;
        m_cand = -1;
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_mask[i]) m_cand = i;
        cur    = (m_ids.size() == 0) ? 0 : m_ids[m_ids.size() - 1] + 1;
        m_uret = uret && !m_halt && (m_ids.size() > 0);
        m_take = (m_cand >= 0) && (m_cand + 1 > cur) && !m_halt && !uret && !ecall;
        e_red  = m_uret || m_take;
        e_pc   = 0;
        if (m_uret)      e_pc = m_pcs[m_pcs.size() - 1];
        else if (m_take) e_pc = 32'h100 + 32'(m_cand) * 16;
    endfunction

    function automatic void model_seq();
        if (m_take) begin
            m_ids.push_back(m_cand);
            m_pcs.push_back(pc_next);
            m_pend[m_cand] = 0;
        end
        if (m_uret) begin
            void'(m_ids.pop_back());
            void'(m_pcs.pop_back());
        end
        if (ecall && !m_halt) begin
            if (R1 == 34) m_led = R2;
            if (R1 == 10) m_halt = 1;
`ifdef IRQ_MASK_EN
            if (R1 == 50)
                for (int i = 0; i < N; i++) m_mask[i] = R2[i];
`endif
        end
        for (int i = 0; i < N; i++) begin
            if (irq[i] && !m_prev[i]) m_pend[i] = 1;
            m_prev[i] = irq[i];
        end
    endfunction

    // One clock: compare everything against the model, then advance both.
    task automatic tick();
        model_comb();
        #1;
        chk("redirect", redirect, e_red);
        if (e_red) chk("redirect_pc", redirect_pc, e_pc);
        chk("in_service", in_service, exp_isvc());
        chk("ledData", ledData, m_led);
        chk("halt", halt, m_halt);
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic idle();
        ecall = 0;
        uret  = 0;
        R1    = 0;
        R2    = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        irq = '0;
        idle();
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        rst = 1; irq = '0; pc_next = 0;
        idle();
        model_reset();
        do_reset();

        // Reset state
        #1;
        chk("rst_led", ledData, 0);
        chk("rst_halt", halt, 0);
        chk("rst_isvc", in_service, 0);
        chk("rst_redirect", redirect, 0);

        // ecall print
        ecall = 1; R1 = 34; R2 = 32'hDEADBEEF;
        #1; chk("print_noredir", redirect, 0);
        tick(); idle();
        chk("print_led", ledData, 32'hDEADBEEF);
        tick();

        // Single interrupt and return
        irq = 3'b001; pc_next = 32'h40;
        tick();
        #1; chk("single_red", redirect, 1); chk("single_pc", redirect_pc, 32'h100);
        tick();
        chk("single_isvc", in_service, 3'b001);
        irq = 3'b000; pc_next = 32'h104;
        tick(); tick();
        uret = 1;
        #1; chk("single_ret_pc", redirect_pc, 32'h40);
        tick(); idle();
        chk("single_ret_isvc", in_service, 0);

        // Nesting
        irq = 3'b001; pc_next = 32'h40;
        tick(); tick();
        irq = 3'b101; pc_next = 32'h108;
        tick();
        #1; chk("nest_pc", redirect_pc, 32'h120);
        tick();
        chk("nest_isvc", in_service, 3'b101);
        uret = 1;
        #1; chk("nest_ret1", redirect_pc, 32'h108);
        tick();
        #1; chk("nest_ret2", redirect_pc, 32'h40);
        tick(); idle();
        chk("nest_isvc0", in_service, 0);
        irq = 3'b000;
        tick();

        // Priority between simultaneous edges
        irq = 3'b011; pc_next = 32'h40;
        tick();
        #1; chk("prio_pc", redirect_pc, 32'h110);
        tick();
        pc_next = 32'h50;
        #1; chk("prio_blocked", redirect, 0);
        tick();
        uret = 1;
        #1; chk("prio_ret", redirect_pc, 32'h40);
        tick(); idle();
        #1; chk("prio_ch0_pc", redirect_pc, 32'h100);
        tick();
        chk("prio_ch0_isvc", in_service, 3'b001);
        uret = 1;
        #1; chk("prio_ch0_ret", redirect_pc, 32'h50);
        tick(); idle();
        irq = 3'b000;
        tick();

        // uret beats a same-cycle take candidate
        irq = 3'b001; pc_next = 32'h40;
        tick(); tick();
        irq = 3'b011; pc_next = 32'h60;
        tick();
        uret = 1;
        #1; chk("uretwin_pc", redirect_pc, 32'h40);
        tick(); idle();
        #1; chk("uretwin_next", redirect_pc, 32'h110);
        tick();
        chk("uretwin_isvc", in_service, 3'b010);
        uret = 1;
        tick(); idle();
        irq = 3'b000;
        tick();

        // Halt, then reset
        ecall = 1; R1 = 10;
        tick(); idle();
        chk("halt_set", halt, 1);
        irq = 3'b100;
        tick();
        #1; chk("halt_noredir", redirect, 0);
        tick(); tick();
        do_reset();
        chk("post_rst_halt", halt, 0);
        chk("post_rst_isvc", in_service, 0);
        chk("post_rst_led", ledData, 0);
        tick();

`ifdef IRQ_MASK_EN
        // Masking
        ecall = 1; R1 = 50; R2 = 0;
        tick(); idle();
        irq = 3'b001; pc_next = 32'h70;
        tick();
        #1; chk("mask_noredir", redirect, 0);
        tick();
        ecall = 1; R1 = 50; R2 = 1;
        tick(); idle();
        #1; chk("unmask_pc", redirect_pc, 32'h100);
        tick();
        uret = 1;
        tick(); idle();
        irq = 3'b000;
        tick();
`endif

        // Random phase against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            r = $urandom;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
            pc_next = {$urandom, 2'b00} & 32'h0000_FFFC;
            uret    = (r[3:0] < 3);
            ecall   = (r[7:4] == 0);
            case (r[9:8])
                2'd0: R1 = 34;
                2'd1: R1 = 50;
                2'd2: R1 = 7;
                default: R1 = 34;
            endcase
            R2 = $urandom;
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
